// File: rtl/wb_bus_if_pkg.sv
// Shared types and widths for the Wishbone classic master bridge.
// Imported by the bridge and by anything that needs to see its state.
package wb_bus_if_pkg;

  localparam int STALL_BUS_W = 6;
  localparam int WB_BUS_W    = 32;

  typedef enum logic [1:0] {
    WbIdle      = 2'd0,
    WbBusy      = 2'd1,
    WbWaitStall = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_bus_if.sv
// Wishbone classic master bridge: turns a single-cycle core memory request into
// one Wishbone transaction, holding the pipeline until ack, error or timeout.
module wb_bus_if
  import wb_bus_if_pkg::*;
#(
  parameter int ADDR_W      = WB_BUS_W,
  parameter int DATA_W      = WB_BUS_W,
  parameter int SEL_W       = DATA_W / 8,
  parameter int STALL_W     = STALL_BUS_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  input  logic               cpu_ce_i,
  input  logic               cpu_we_i,
  input  logic [ADDR_W-1:0]  cpu_addr_i,
  input  logic [SEL_W-1:0]   cpu_sel_i,
  input  logic [DATA_W-1:0]  cpu_data_i,
  output logic [DATA_W-1:0]  cpu_data_o,
  output logic               stallreq_o,
  output logic               bus_err_o,
  output logic [ADDR_W-1:0]  wb_adr_o,
  output logic [DATA_W-1:0]  wb_dat_o,
  input  logic [DATA_W-1:0]  wb_dat_i,
  output logic               wb_we_o,
  output logic [SEL_W-1:0]   wb_sel_o,
  output logic               wb_stb_o,
  output logic               wb_cyc_o,
  input  logic               wb_ack_i,
  input  logic               wb_err_i
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  wb_state_e          state_reg, state_next;
  logic [ADDR_W-1:0]  adr_reg, adr_next;
  logic [DATA_W-1:0]  dat_reg, dat_next;
  logic               we_reg, we_next;
  logic [SEL_W-1:0]   sel_reg, sel_next;
  logic               cyc_reg, cyc_next;
  logic [DATA_W-1:0]  rd_buf_reg, rd_buf_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               bus_err_reg, bus_err_next;

  logic timeout_hit;
  logic err_event;
  logic stalled;

  // A silent slave is treated exactly like one that raised wb_err_i.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));
  assign err_event   = wb_err_i | timeout_hit;
  assign stalled     = (stall_i != '0);

  always_comb begin
    state_next   = state_reg;
    adr_next     = adr_reg;
    dat_next     = dat_reg;
    we_next      = we_reg;
    sel_next     = sel_reg;
    cyc_next     = cyc_reg;
    rd_buf_next  = rd_buf_reg;
    cnt_next     = cnt_reg;
    bus_err_next = 1'b0;
    cpu_data_o   = '0;
    stallreq_o   = 1'b0;

    case (state_reg)
      WbIdle: begin
        stallreq_o = cpu_ce_i & ~flush_i;
        if (cpu_ce_i && !flush_i) begin
          adr_next   = cpu_addr_i;
          dat_next   = cpu_we_i ? cpu_data_i : '0;
          we_next    = cpu_we_i;
          sel_next   = cpu_sel_i;
          cyc_next   = 1'b1;
          cnt_next   = '0;
          state_next = WbBusy;
        end
      end

      WbBusy: begin
        if (err_event || wb_ack_i || flush_i) begin
          adr_next = '0;
          dat_next = '0;
          we_next  = 1'b0;
          sel_next = '0;
          cyc_next = 1'b0;
          cnt_next = '0;
          if (err_event) begin
            rd_buf_next  = '0;
            bus_err_next = 1'b1;
            state_next   = (stalled && !flush_i) ? WbWaitStall : WbIdle;
          end else if (wb_ack_i) begin
            rd_buf_next = wb_dat_i;
            // A flushed access still completes on the bus but its data is dropped.
            if (!flush_i && !we_reg) begin
              cpu_data_o = wb_dat_i;
            end
            state_next = (stalled && !flush_i) ? WbWaitStall : WbIdle;
          end else begin
            state_next = WbIdle;
          end
        end else begin
          stallreq_o = 1'b1;
          if (TIMEOUT_CYC != 0) begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

      WbWaitStall: begin
        // Hold the captured word until the rest of the pipeline moves again.
        cpu_data_o = rd_buf_reg;
        if (!stalled || flush_i) begin
          state_next = WbIdle;
        end
      end

      default: begin
        state_next = WbIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= WbIdle;
      adr_reg     <= '0;
      dat_reg     <= '0;
      we_reg      <= 1'b0;
      sel_reg     <= '0;
      cyc_reg     <= 1'b0;
      rd_buf_reg  <= '0;
      cnt_reg     <= '0;
      bus_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      adr_reg     <= adr_next;
      dat_reg     <= dat_next;
      we_reg      <= we_next;
      sel_reg     <= sel_next;
      cyc_reg     <= cyc_next;
      rd_buf_reg  <= rd_buf_next;
      cnt_reg     <= cnt_next;
      bus_err_reg <= bus_err_next;
    end
  end

  assign wb_adr_o  = adr_reg;
  assign wb_dat_o  = dat_reg;
  assign wb_we_o   = we_reg;
  assign wb_sel_o  = sel_reg;
  assign wb_cyc_o  = cyc_reg;
  assign wb_stb_o  = cyc_reg;
  assign bus_err_o = bus_err_reg;

endmodule

// File: tb/tb_wb_bus_if.sv
// Directed bench for wb_bus_if: a default-timeout bridge for the main sequences
// and a TIMEOUT_CYC=4 bridge for the silent-slave abort.
module tb_wb_bus_if;
  import wb_bus_if_pkg::*;

  logic        clk;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        cpu_ce_i;
  logic        cpu_ce2_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_i;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  logic [31:0] cpu_data_o, wb_adr_o, wb_dat_o;
  logic        stallreq_o, bus_err_o, wb_we_o, wb_stb_o, wb_cyc_o;
  logic [3:0]  wb_sel_o;

  logic [31:0] cpu_data2_o, wb_adr2_o, wb_dat2_o;
  logic        stallreq2_o, bus_err2_o, wb_we2_o, wb_stb2_o, wb_cyc2_o;
  logic [3:0]  wb_sel2_o;

  int checks = 0;
  int errors = 0;

  wb_bus_if dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .bus_err_o(bus_err_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  wb_bus_if #(.TIMEOUT_CYC(4)) dut_to (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce2_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data2_o),
    .stallreq_o(stallreq2_o), .bus_err_o(bus_err2_o), .wb_adr_o(wb_adr2_o),
    .wb_dat_o(wb_dat2_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we2_o),
    .wb_sel_o(wb_sel2_o), .wb_stb_o(wb_stb2_o), .wb_cyc_o(wb_cyc2_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; checks run 1ns later, mid-cycle.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; stall_i = '0; flush_i = 0; cpu_ce_i = 0; cpu_ce2_i = 0;
    cpu_we_i = 0; cpu_addr_i = '0; cpu_sel_i = '0; cpu_data_i = '0;
    wb_dat_i = '0; wb_ack_i = 0; wb_err_i = 0;
    #12;
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_stallreq", stallreq_o, 0);
    chk("rst_data", cpu_data_o, 0);
    chk("rst_bus_err", bus_err_o, 0);
    next_cycle(); rst = 1'b1;
    next_cycle();

    // Read, zero-wait slave
    cpu_ce_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h100; cpu_sel_i = 4'hF; #1;
    $display("txn read0 addr=%h", cpu_addr_i);
    chk("rd0_c0_stallreq", stallreq_o, 1);
    chk("rd0_c0_cyc", wb_cyc_o, 0);
    next_cycle(); cpu_ce_i = 0; wb_ack_i = 1; wb_dat_i = 32'hDEADBEEF; #1;
    chk("rd0_c1_cyc", wb_cyc_o, 1);
    chk("rd0_c1_stb", wb_stb_o, 1);
    chk("rd0_c1_adr", wb_adr_o, 32'h100);
    chk("rd0_c1_data", cpu_data_o, 32'hDEADBEEF);
    chk("rd0_c1_stallreq", stallreq_o, 0);
    next_cycle(); wb_ack_i = 0; #1;
    chk("rd0_c2_cyc", wb_cyc_o, 0);
    chk("rd0_c2_state", dut.state_reg, WbIdle);
    chk("rd0_c2_data", cpu_data_o, 0);

    // Write, 3 wait states
    next_cycle(); cpu_ce_i = 1; cpu_we_i = 1; cpu_sel_i = 4'b0011;
    cpu_addr_i = 32'h180; cpu_data_i = 32'h1234; #1;
    $display("txn write3 addr=%h data=%h", cpu_addr_i, cpu_data_i);
    chk("wr3_c0_stallreq", stallreq_o, 1);
    for (int i = 1; i <= 3; i++) begin
      next_cycle(); cpu_ce_i = 0; cpu_we_i = 0; #1;
      chk($sformatf("wr3_c%0d_dat", i), wb_dat_o, 32'h1234);
      chk($sformatf("wr3_c%0d_sel", i), wb_sel_o, 4'b0011);
      chk($sformatf("wr3_c%0d_we", i), wb_we_o, 1);
      chk($sformatf("wr3_c%0d_stallreq", i), stallreq_o, 1);
    end
    next_cycle(); wb_ack_i = 1; wb_dat_i = 32'h77777777; #1;
    chk("wr3_c4_cyc", wb_cyc_o, 1);
    chk("wr3_c4_dat", wb_dat_o, 32'h1234);
    chk("wr3_c4_stallreq", stallreq_o, 0);
    chk("wr3_c4_data", cpu_data_o, 0);
    next_cycle(); wb_ack_i = 0; #1;
    chk("wr3_c5_cyc", wb_cyc_o, 0);
    chk("wr3_c5_dat", wb_dat_o, 0);
    chk("wr3_c5_sel", wb_sel_o, 0);

    // Read acked while the pipeline is stalled elsewhere
    next_cycle(); cpu_ce_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h200; cpu_sel_i = 4'hF; #1;
    $display("txn read_stall addr=%h", cpu_addr_i);
    next_cycle(); cpu_ce_i = 0; wb_ack_i = 1; wb_dat_i = 32'hCAFEF00D; stall_i = 6'b000011; #1;
    chk("rds_ack_data", cpu_data_o, 32'hCAFEF00D);
    chk("rds_ack_stallreq", stallreq_o, 0);
    for (int i = 0; i < 2; i++) begin
      next_cycle(); wb_ack_i = 0; wb_dat_i = 32'h11111111; #1;
      chk($sformatf("rds_w%0d_state", i), dut.state_reg, WbWaitStall);
      chk($sformatf("rds_w%0d_data", i), cpu_data_o, 32'hCAFEF00D);
      chk($sformatf("rds_w%0d_stallreq", i), stallreq_o, 0);
      chk($sformatf("rds_w%0d_cyc", i), wb_cyc_o, 0);
    end
    next_cycle(); stall_i = '0; #1;
    chk("rds_release_data", cpu_data_o, 32'hCAFEF00D);
    next_cycle(); #1;
    chk("rds_idle_state", dut.state_reg, WbIdle);
    chk("rds_idle_data", cpu_data_o, 0);

    // Bus error, with a simultaneous ack to exercise priority
    next_cycle(); cpu_ce_i = 1; cpu_addr_i = 32'h300; #1;
    $display("txn read_err addr=%h", cpu_addr_i);
    next_cycle(); cpu_ce_i = 0; wb_err_i = 1; wb_ack_i = 1; wb_dat_i = 32'h55555555; #1;
    chk("err_c1_data", cpu_data_o, 0);
    chk("err_c1_stallreq", stallreq_o, 0);
    chk("err_c1_bus_err", bus_err_o, 0);
    next_cycle(); wb_err_i = 0; wb_ack_i = 0; #1;
    chk("err_c2_bus_err", bus_err_o, 1);
    chk("err_c2_cyc", wb_cyc_o, 0);
    next_cycle(); #1;
    chk("err_c3_bus_err", bus_err_o, 0);

    // Timeout (TIMEOUT_CYC=4), silent slave
    next_cycle(); cpu_ce2_i = 1; cpu_addr_i = 32'h500; #1;
    $display("txn timeout addr=%h", cpu_addr_i);
    chk("to_c0_stallreq", stallreq2_o, 1);
    for (int i = 1; i <= 3; i++) begin
      next_cycle(); cpu_ce2_i = 0; #1;
      chk($sformatf("to_c%0d_cyc", i), wb_cyc2_o, 1);
      chk($sformatf("to_c%0d_stallreq", i), stallreq2_o, 1);
      chk($sformatf("to_c%0d_bus_err", i), bus_err2_o, 0);
    end
    next_cycle(); #1;
    chk("to_c4_cyc", wb_cyc2_o, 1);
    chk("to_c4_stallreq", stallreq2_o, 0);
    next_cycle(); #1;
    chk("to_c5_cyc", wb_cyc2_o, 0);
    chk("to_c5_bus_err", bus_err2_o, 1);
    next_cycle(); #1;
    chk("to_c6_bus_err", bus_err2_o, 0);

    // Flush in BUSY cycle 2
    next_cycle(); cpu_ce_i = 1; cpu_addr_i = 32'h400; #1;
    $display("txn flush addr=%h", cpu_addr_i);
    next_cycle(); cpu_ce_i = 0; #1;
    chk("fl_c1_stallreq", stallreq_o, 1);
    next_cycle(); flush_i = 1; #1;
    chk("fl_c2_stallreq", stallreq_o, 0);
    chk("fl_c2_cyc", wb_cyc_o, 1);
    next_cycle(); flush_i = 0; #1;
    chk("fl_c3_cyc", wb_cyc_o, 0);
    chk("fl_c3_stb", wb_stb_o, 0);
    chk("fl_c3_bus_err", bus_err_o, 0);

    // Request together with flush in IDLE is dropped
    next_cycle(); cpu_ce_i = 1; flush_i = 1; #1;
    $display("txn idle_flush");
    chk("if_stallreq", stallreq_o, 0);
    next_cycle(); cpu_ce_i = 0; flush_i = 0; #1;
    chk("if_cyc", wb_cyc_o, 0);

    // Asynchronous reset mid-transaction
    next_cycle(); cpu_ce_i = 1; cpu_we_i = 1; cpu_addr_i = 32'h600; cpu_data_i = 32'hABCD; #1;
    $display("txn reset_mid addr=%h", cpu_addr_i);
    next_cycle(); cpu_ce_i = 0; cpu_we_i = 0; #1;
    chk("rm_busy_cyc", wb_cyc_o, 1);
    #1 rst = 1'b0; #1;
    chk("rm_cyc", wb_cyc_o, 0);
    chk("rm_stb", wb_stb_o, 0);
    chk("rm_adr", wb_adr_o, 0);
    chk("rm_dat", wb_dat_o, 0);
    chk("rm_we", wb_we_o, 0);
    chk("rm_stallreq", stallreq_o, 0);
    chk("rm_bus_err", bus_err_o, 0);
    chk("rm_state", dut.state_reg, WbIdle);
    next_cycle(); rst = 1'b1;
    next_cycle(); #1;
    chk("rm_after_cyc", wb_cyc_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
